// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard_mc pipeline hazard unit.
// Optional feature macro: HAZARD_MC_BRANCH_FWD_EN (decode-stage branch forwarding/stall).
package hazard_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int MDU_CNT_W  = 4;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/hazard_mc_mdu_tracker.sv
// Single-entry scoreboard for one in-flight multi-cycle MDU operation:
// latency counter, destination register and the RAW/WAW/structural hazard terms.
module mdu_tracker
  import hazard_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int MDU_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic              start,
  input  logic              reg_write,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] write_reg,
  input  logic [REG_AW-1:0] dst_in,
  output logic              busy,
  output logic              wb,
  output logic [REG_AW-1:0] wb_reg,
  output logic              raw,
  output logic              waw,
  output logic              struct_hz
);

  localparam logic [MDU_CNT_W-1:0] LOAD_CNT = MDU_CNT_W'(MDU_LAT - 1);

  mdu_state_e           state, state_nxt;
  logic [MDU_CNT_W-1:0] cnt, cnt_nxt;
  logic [REG_AW-1:0]    dst, dst_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= MDU_IDLE;
      cnt   <= '0;
      dst   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dst   <= dst_nxt;
    end
  end

  // NOTE: defaults first so every path assigns every target and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dst_nxt   = dst;
    if (issue) begin
      // Also covers the write-back cycle: a new op reloads the tracker back-to-back.
      state_nxt = MDU_RUN;
      cnt_nxt   = LOAD_CNT;
      dst_nxt   = dst_in;
    end else if (state == MDU_RUN) begin
      if (cnt != '0) begin
        cnt_nxt = cnt - MDU_CNT_W'(1);
      end else begin
        state_nxt = MDU_IDLE;
        dst_nxt   = '0;
      end
    end
  end

  always_comb begin
    busy      = (state == MDU_RUN);
    wb        = busy && (cnt == '0);
    wb_reg    = busy ? dst : '0;
    // RAW holds through the write-back cycle; the consumer reads the regfile a cycle later.
    raw       = busy && (dst != '0) && ((rs == dst) || (rt == dst));
    waw       = busy && reg_write && (write_reg == dst) && (dst != '0);
    struct_hz = start && busy && (cnt != '0);
  end

endmodule

// File: rtl/hazard_mc.sv
// Five-stage MIPS hazard unit: E/M/W forwarding, load-use and branch stalls, MDU tracking.
// Define HAZARD_MC_BRANCH_FWD_EN to resolve branches in decode (ForwardAD/BD and branch stall).
module hazard_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int MDU_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              BranchD,
  input  logic              RegWriteD,
  input  logic              MduStartD,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] WriteRegD,
  input  logic [REG_AW-1:0] MduDstD,
  input  logic              MemToRegE,
  input  logic              RegWriteE,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic              MemtoRegM,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] WriteRegW,
  output logic              stallF,
  output logic              stallD,
  output logic              FlushE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MduBusy,
  output logic              MduWb,
  output logic [REG_AW-1:0] MduWbReg
);

  logic              lwstall, branchstall, mdustall, stall;
  logic              fwd_ad, fwd_bd;
  fwd_sel_e          fwd_ae, fwd_be;
  logic              mdu_issue, mdu_busy, mdu_wb, mdu_raw, mdu_waw, mdu_struct;
  logic [REG_AW-1:0] mdu_wb_reg;

  function automatic fwd_sel_e fwd_sel(input logic [REG_AW-1:0] src);
    if (src != '0 && src == WriteRegM && RegWriteM) return FWD_M;
    if (src != '0 && src == WriteRegW && RegWriteW) return FWD_W;
    return FWD_NONE;
  endfunction

  assign fwd_ae  = fwd_sel(RsE);
  assign fwd_be  = fwd_sel(RtE);
  assign lwstall = MemToRegE && ((RtE == RsD) || (RtE == RtD));

`ifdef HAZARD_MC_BRANCH_FWD_EN
  assign fwd_ad      = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
  assign fwd_bd      = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;
  assign branchstall = BranchD &&
                       ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                        (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
`else
  logic unused_branch;
  assign unused_branch = ^{BranchD, RegWriteE, WriteRegE, MemtoRegM};
  assign fwd_ad        = 1'b0;
  assign fwd_bd        = 1'b0;
  assign branchstall   = 1'b0;
`endif

  assign mdustall  = mdu_raw | mdu_waw | mdu_struct;
  assign stall     = lwstall | branchstall | mdustall;
  assign mdu_issue = reset && MduStartD && !stall;

  mdu_tracker #(
    .REG_AW  (REG_AW),
    .MDU_LAT (MDU_LAT)
  ) u_mdu_tracker (
    .clk       (clk),
    .reset     (reset),
    .issue     (mdu_issue),
    .start     (MduStartD),
    .reg_write (RegWriteD),
    .rs        (RsD),
    .rt        (RtD),
    .write_reg (WriteRegD),
    .dst_in    (MduDstD),
    .busy      (mdu_busy),
    .wb        (mdu_wb),
    .wb_reg    (mdu_wb_reg),
    .raw       (mdu_raw),
    .waw       (mdu_waw),
    .struct_hz (mdu_struct)
  );

  // Tracker state is cleared only at the next edge, so outputs are gated while reset is low.
  assign stallF    = reset && stall;
  assign stallD    = reset && stall;
  assign FlushE    = reset && stall;
  assign ForwardAD = reset && fwd_ad;
  assign ForwardBD = reset && fwd_bd;
  assign ForwardAE = reset ? fwd_ae : FWD_NONE;
  assign ForwardBE = reset ? fwd_be : FWD_NONE;
  assign MduBusy   = reset && mdu_busy;
  assign MduWb     = reset && mdu_wb;
  assign MduWbReg  = reset ? mdu_wb_reg : '0;

endmodule

// File: tb/tb_hazard_mc.sv
// Directed self-checking bench for hazard_mc (REG_AW=5, MDU_LAT=4).
// Branch expectations follow HAZARD_MC_BRANCH_FWD_EN the same way the build does.
module tb_hazard_mc;

`ifdef HAZARD_MC_BRANCH_FWD_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       BranchD, RegWriteD, MduStartD;
  logic [4:0] RsD, RtD, WriteRegD, MduDstD;
  logic       MemToRegE, RegWriteE;
  logic [4:0] RsE, RtE, WriteRegE;
  logic       MemtoRegM, RegWriteM;
  logic [4:0] WriteRegM;
  logic       RegWriteW;
  logic [4:0] WriteRegW;
  logic       stallF, stallD, FlushE, ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MduBusy, MduWb;
  logic [4:0] MduWbReg;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_mc #(.REG_AW(5), .MDU_LAT(4)) dut (
    .clk(clk), .reset(reset),
    .BranchD(BranchD), .RegWriteD(RegWriteD), .MduStartD(MduStartD),
    .RsD(RsD), .RtD(RtD), .WriteRegD(WriteRegD), .MduDstD(MduDstD),
    .MemToRegE(MemToRegE), .RegWriteE(RegWriteE),
    .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
    .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM), .WriteRegM(WriteRegM),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
    .stallF(stallF), .stallD(stallD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MduBusy(MduBusy), .MduWb(MduWb), .MduWbReg(MduWbReg)
  );

  wire [15:0] all_out = {stallF, stallD, FlushE, ForwardAD, ForwardBD,
                         ForwardAE, ForwardBE, MduBusy, MduWb, MduWbReg};
  wire [2:0]  stall3  = {stallF, stallD, FlushE};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    BranchD = 0; RegWriteD = 0; MduStartD = 0;
    RsD = 0; RtD = 0; WriteRegD = 0; MduDstD = 0;
    MemToRegE = 0; RegWriteE = 0; RsE = 0; RtE = 0; WriteRegE = 0;
    MemtoRegM = 0; RegWriteM = 0; WriteRegM = 0;
    RegWriteW = 0; WriteRegW = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();

    // Reset low: outputs forced to 0 even when inputs ask for a forward.
    RegWriteM = 1; WriteRegM = 1; RsE = 1;
    #1;
    check("rst_low_all_zero", all_out, 16'h0);

    reset = 1'b1;
    clear_inputs();
    #1;
    check("rst_release_zero", all_out, 16'h0);
    tick();
    check("post_rst_idle", all_out, 16'h0);

    // E-stage forwarding with M priority over W.
    RegWriteM = 1; WriteRegM = 1; RegWriteW = 1; WriteRegW = 1; RsE = 1;
    #1;
    check("fwd_ae_m_prio", ForwardAE, 2'b10);
    RsE = 0;
    #1;
    check("fwd_ae_reg0", ForwardAE, 2'b00);
    RsE = 1; RegWriteM = 0;
    #1;
    check("fwd_ae_w", ForwardAE, 2'b01);
    RegWriteM = 1; WriteRegM = 2; RtE = 2;
    #1;
    check("fwd_ae_w_m_other", ForwardAE, 2'b01);
    check("fwd_be_m", ForwardBE, 2'b10);
    check("fwd_no_stall", stall3, 3'b000);

    // Decode comparator forwarding from M.
    clear_inputs();
    RegWriteM = 1; WriteRegM = 4; RsD = 4; RtD = 4;
    #1;
    check("fwd_ad", ForwardAD, BR_EN);
    check("fwd_bd", ForwardBD, BR_EN);
    RsD = 0; RtD = 0; WriteRegM = 0;
    #1;
    check("fwd_ad_reg0", ForwardAD, 1'b0);

    // Load-use stall.
    clear_inputs();
    MemToRegE = 1; RtE = 2; RsD = 2;
    #1;
    check("lwstall_on", stall3, 3'b111);
    MemToRegE = 0;
    #1;
    check("lwstall_off", stall3, 3'b000);

    // Decode-branch stall against E and M producers.
    clear_inputs();
    BranchD = 1; RegWriteE = 1; WriteRegE = 3; RsD = 3;
    #1;
    check("brstall_e", stall3, {3{BR_EN}});
    RegWriteE = 0; MemtoRegM = 1; WriteRegM = 3; RsD = 0; RtD = 3;
    #1;
    check("brstall_m", stall3, {3{BR_EN}});
    BranchD = 0;
    #1;
    check("brstall_nobranch", stall3, 3'b000);

    // MDU issue, dst=5, RAW stall through the write-back cycle.
    clear_inputs();
    MduStartD = 1; MduDstD = 5;
    #1;
    check("mdu_issue_nostall", stall3, 3'b000);
    tick();
    MduStartD = 0; RsD = 5;
    #1;
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("mdu_busy_c%0d", i), MduBusy, (i <= 4));
      check($sformatf("mdu_wb_c%0d", i), MduWb, (i == 4));
      check($sformatf("mdu_raw_c%0d", i), stallD, (i <= 4));
      if (i == 4) check("mdu_wbreg_5", MduWbReg, 5'd5);
      if (i == 5) check("mdu_wbreg_idle", MduWbReg, 5'd0);
      if (i < 5) tick();
    end

    // Structural stall, then back-to-back issue in the write-back cycle.
    clear_inputs();
    MduStartD = 1; MduDstD = 6;
    #1;
    tick();
    MduStartD = 0;
    tick();
    MduStartD = 1; MduDstD = 7;
    #1;
    check("struct_cnt2", stallD, 1'b1);
    tick();
    check("struct_cnt1", stallD, 1'b1);
    tick();
    check("b2b_wb", MduWb, 1'b1);
    check("b2b_wbreg_6", MduWbReg, 5'd6);
    check("b2b_no_stall", stallD, 1'b0);
    tick();
    MduStartD = 0;
    #1;
    for (int j = 1; j <= 4; j++) begin
      check($sformatf("b2b_busy_c%0d", j), MduBusy, 1'b1);
      check($sformatf("b2b_wb_c%0d", j), MduWb, (j == 4));
      if (j == 1) begin
        RegWriteD = 1; WriteRegD = 7;
        #1;
        check("waw_stall", stall3, 3'b111);
        RegWriteD = 0; WriteRegD = 0;
        #1;
        check("waw_clear", stall3, 3'b000);
      end
      if (j == 4) check("b2b_wbreg_7", MduWbReg, 5'd7);
      if (j < 4) tick();
    end
    tick();
    check("b2b_idle", MduBusy, 1'b0);

    // Reset mid-operation abandons the op.
    clear_inputs();
    MduStartD = 1; MduDstD = 9;
    #1;
    tick();
    MduStartD = 0;
    tick();
    check("rst_mid_busy", MduBusy, 1'b1);
    reset = 1'b0;
    RegWriteM = 1; WriteRegM = 1; RsE = 1; RsD = 9;
    #1;
    check("rst_mid_all_zero", all_out, 16'h0);
    tick();
    reset = 1'b1;
    clear_inputs();
    #1;
    check("rst_mid_cleared", MduBusy, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("rst_mid_no_wb_%0d", k), MduWb, 1'b0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
